// File: rtl/unstriping.sv
// -----------------------------------------------------------------------------
// unstriping
//   Receive-side lane merger. Four 8-bit lanes arrive as 4-byte columns
//   (lane 0 = oldest byte). Columns are queued in a small buffer and
//   serialized lane0..lane3 at one byte per clock toward the mux/link layer.
//   Every serialized byte is also checked against STP/END framing. The block
//   tracks packet state and reports the data length of each packet.
//
// Ports
//   clk          in   clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   RL0..RL3     in   lane bytes of the incoming column (RL0 is emitted first)
//   col_valid    in   RL0..RL3 hold a valid column
//   col_ready    out  buffer can accept a column (from registered count only)
//   toMux        out  serialized byte (registered), IDL_SYM when idle
//   out_valid    out  toMux carries a column byte
//   in_packet    out  high from the emitted STP through the emitted END
//   framing_err  out  one-cycle pulse, framing violation on the current toMux byte
//   pkt_done     out  one-cycle pulse with the emitted END of a valid packet
//   pkt_len      out  data bytes between STP and END, held until the next END
//
// Build option
//   UNSTRIPING_SKP_DROP_EN : when defined, a column made of four SKP_SYM bytes
//   is popped from the buffer but never serialized.
// -----------------------------------------------------------------------------
module unstriping #(
  parameter int         DEPTH   = 2,
  parameter logic [7:0] IDL_SYM = 8'h7C,
  parameter logic [7:0] SKP_SYM = 8'h1C,
  parameter logic [7:0] STP_SYM = 8'hFB,
  parameter logic [7:0] END_SYM = 8'hFD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] RL0,
  input  logic [7:0] RL1,
  input  logic [7:0] RL2,
  input  logic [7:0] RL3,
  input  logic       col_valid,
  output logic       col_ready,
  output logic [7:0] toMux,
  output logic       out_valid,
  output logic       in_packet,
  output logic       framing_err,
  output logic       pkt_done,
  output logic [7:0] pkt_len
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_SER} state_t;

  // Column buffer. Lane 0 lives in bits [7:0].
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_ready_en;

  // Serializer
  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_next;
  logic [1:0]  w_idx_inc;
  logic [31:0] r_col;
  logic [31:0] w_col_next;
  logic [7:0]  r_tomux;
  logic        r_out_valid;

  // Framing
  logic       r_in_packet;
  logic       w_in_packet_next;
  logic       r_framing_err;
  logic       w_framing_err_next;
  logic       r_pkt_done;
  logic       w_pkt_done_next;
  logic [7:0] r_pkt_len;
  logic [7:0] w_pkt_len_next;
  logic [7:0] r_len_cnt;
  logic [7:0] w_len_cnt_next;
  logic       w_cur_pkt;

  logic        w_push;
  logic        w_pop;
  logic        w_emit;
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [31:0] w_head;
  logic        w_is_skp_col;

  // r_ready_en keeps col_ready low during reset and lets it rise one edge
  // after reset is released.
  assign col_ready = r_ready_en && (r_count < FULL);
  assign w_push    = col_valid && col_ready;

  // The head column is read combinationally so a column accepted into an
  // empty buffer reaches toMux on the very next edge.
  assign w_head    = r_mem[r_rd_ptr];
  assign w_idx_inc = r_idx + 2'd1;

`ifdef UNSTRIPING_SKP_DROP_EN
  assign w_is_skp_col = (w_head == {4{SKP_SYM}});
`else
  assign w_is_skp_col = 1'b0;
`endif

  // The packet closes on the edge after the END byte, so a pkt_done pulse
  // on the current byte means the next byte is already outside the packet.
  assign w_cur_pkt = r_in_packet && !r_pkt_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {RL3, RL2, RL1, RL0};
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Serializer next state. A new column is loaded when idle or while the
  // last lane of the current column is on toMux, which keeps back-to-back
  // columns gapless.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_col_next   = r_col;
    w_pop        = 1'b0;
    w_emit       = 1'b0;
    w_lane       = 2'd0;
    w_byte       = IDL_SYM;
    if (r_state == S_SER && r_idx != 2'd3) begin
      w_idx_next = w_idx_inc;
      w_lane     = w_idx_inc;
      w_byte     = r_col[{w_idx_inc, 3'b000} +: 8];
      w_emit     = 1'b1;
    end else if (r_count != '0) begin
      w_pop = 1'b1;
      if (w_is_skp_col) begin
        // Dropped skip column: one idle cycle, the next column loads from IDLE.
        w_state_next = S_IDLE;
      end else begin
        w_state_next = S_SER;
        w_idx_next   = 2'd0;
        w_col_next   = w_head;
        w_lane       = 2'd0;
        w_byte       = w_head[7:0];
        w_emit       = 1'b1;
      end
    end else begin
      w_state_next = S_IDLE;
    end
  end

  // Framing check on the byte about to be registered onto toMux.
  always_comb begin
    w_in_packet_next   = w_cur_pkt;
    w_framing_err_next = 1'b0;
    w_pkt_done_next    = 1'b0;
    w_pkt_len_next     = r_pkt_len;
    w_len_cnt_next     = r_len_cnt;
    if (w_emit) begin
      if (w_byte == STP_SYM) begin
        if (!w_cur_pkt && w_lane == 2'd0) begin
          w_in_packet_next = 1'b1;
          w_len_cnt_next   = 8'd0;
        end else begin
          w_framing_err_next = 1'b1;
        end
      end else if (w_byte == END_SYM) begin
        if (w_cur_pkt) begin
          w_pkt_done_next = 1'b1;
          w_pkt_len_next  = r_len_cnt;
        end else begin
          w_framing_err_next = 1'b1;
        end
      end else if (w_cur_pkt) begin
        if (r_len_cnt != 8'hFF) begin
          w_len_cnt_next = r_len_cnt + 8'd1;
        end
      end else if (w_byte != IDL_SYM && w_byte != SKP_SYM) begin
        w_framing_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_ready_en    <= 1'b0;
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_col         <= '0;
      r_tomux       <= IDL_SYM;
      r_out_valid   <= 1'b0;
      r_in_packet   <= 1'b0;
      r_framing_err <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_pkt_len     <= 8'd0;
      r_len_cnt     <= 8'd0;
    end else begin
      r_ready_en    <= 1'b1;
      r_count       <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_col         <= w_col_next;
      r_tomux       <= w_emit ? w_byte : IDL_SYM;
      r_out_valid   <= w_emit;
      r_in_packet   <= w_in_packet_next;
      r_framing_err <= w_framing_err_next;
      r_pkt_done    <= w_pkt_done_next;
      r_pkt_len     <= w_pkt_len_next;
      r_len_cnt     <= w_len_cnt_next;
    end
  end

  assign toMux       = r_tomux;
  assign out_valid   = r_out_valid;
  assign in_packet   = r_in_packet;
  assign framing_err = r_framing_err;
  assign pkt_done    = r_pkt_done;
  assign pkt_len     = r_pkt_len;

endmodule

// File: tb/tb_unstriping.sv
// -----------------------------------------------------------------------------
// tb_unstriping
//   Self-checking bench for unstriping. Accepted columns are turned into an
//   expected byte stream (with lane tags); each emitted byte is matched in
//   order and its framing flags are predicted from the packet rules.
// -----------------------------------------------------------------------------
module tb_unstriping;

  localparam logic [7:0] IDL  = 8'h7C;
  localparam logic [7:0] SKP  = 8'h1C;
  localparam logic [7:0] STP  = 8'hFB;
  localparam logic [7:0] ENDS = 8'hFD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] RL0 = IDL, RL1 = IDL, RL2 = IDL, RL3 = IDL;
  logic       col_valid = 1'b0;
  logic       col_ready;
  logic [7:0] toMux;
  logic       out_valid;
  logic       in_packet;
  logic       framing_err;
  logic       pkt_done;
  logic [7:0] pkt_len;

  always #5 clk = ~clk;

  unstriping dut (
    .clk(clk), .reset(reset),
    .RL0(RL0), .RL1(RL1), .RL2(RL2), .RL3(RL3),
    .col_valid(col_valid), .col_ready(col_ready),
    .toMux(toMux), .out_valid(out_valid), .in_packet(in_packet),
    .framing_err(framing_err), .pkt_done(pkt_done), .pkt_len(pkt_len)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [9:0] exp_q[$];   // {lane, byte}
  bit         m_inpkt = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_len = 8'd0;

  function automatic logic [31:0] col4(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [7:0] rand_sym();
    case ($urandom_range(0, 7))
      0: return IDL;
      1: return SKP;
      2: return STP;
      3: return ENDS;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic drive_col(input logic [31:0] c);
    {RL3, RL2, RL1, RL0} = c;
    col_valid = 1'b1;
  endtask

  // One clock: advance, update the model, compare every output.
  task automatic step(output bit acc);
    bit          rst;
    bit          drop;
    logic [31:0] c;
    logic [9:0]  e;
    logic [1:0]  lane;
    logic [7:0]  b;
    bit          x_err, x_done, x_in;
    rst = reset;
    acc = col_valid && col_ready && !reset;
    c   = {RL3, RL2, RL1, RL0};
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_inpkt = 1'b0; m_cnt = 0; m_len = 8'd0;
      checks++;
      if (col_ready !== 1'b0 || out_valid !== 1'b0 || toMux !== IDL || in_packet !== 1'b0 ||
          framing_err !== 1'b0 || pkt_done !== 1'b0 || pkt_len !== 8'd0) begin
        errors++;
        $display("FAIL reset_state: ready=%b valid=%b toMux=%h inpkt=%b ferr=%b done=%b len=%0d, required 0 0 7c 0 0 0 0",
                 col_ready, out_valid, toMux, in_packet, framing_err, pkt_done, pkt_len);
      end
      return;
    end
    if (acc) begin
      drop = 1'b0;
`ifdef UNSTRIPING_SKP_DROP_EN
      drop = (c == {4{SKP}});
`endif
      if (!drop) for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), c[8*k +: 8]});
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_byte: toMux=%h emitted, required no byte", toMux);
      end else begin
        e = exp_q.pop_front();
        lane = e[9:8];
        b = e[7:0];
        x_err = 1'b0; x_done = 1'b0; x_in = m_inpkt;
        if (b == STP) begin
          if (!m_inpkt && lane == 2'd0) begin x_in = 1'b1; m_cnt = 0; end
          else x_err = 1'b1;
        end else if (b == ENDS) begin
          if (m_inpkt) begin x_done = 1'b1; m_len = 8'(m_cnt); end
          else x_err = 1'b1;
        end else if (m_inpkt) begin
          if (m_cnt < 255) m_cnt++;
        end else if (b != IDL && b != SKP) begin
          x_err = 1'b1;
        end
        if (toMux !== b) begin
          errors++;
          $display("FAIL out_byte: toMux=%h, required %h (lane %0d)", toMux, b, lane);
        end
        checks++;
        if (framing_err !== x_err || pkt_done !== x_done || in_packet !== x_in || pkt_len !== m_len) begin
          errors++;
          $display("FAIL framing: byte=%h ferr=%b done=%b inpkt=%b len=%0d, required %b %b %b %0d",
                   b, framing_err, pkt_done, in_packet, pkt_len, x_err, x_done, x_in, m_len);
        end
        m_inpkt = (b == ENDS && m_inpkt) ? 1'b0 : x_in;
      end
    end else begin
      checks++;
      if (toMux !== IDL || framing_err !== 1'b0 || pkt_done !== 1'b0 ||
          in_packet !== m_inpkt || pkt_len !== m_len) begin
        errors++;
        $display("FAIL idle_out: toMux=%h ferr=%b done=%b inpkt=%b len=%0d, required 7c 0 0 %b %0d",
                 toMux, framing_err, pkt_done, in_packet, pkt_len, m_inpkt, m_len);
      end
    end
  endtask

  task automatic apply_reset();
    bit a;
    col_valid = 1'b0;
    reset = 1'b1;
    step(a);
    step(a);
    reset = 1'b0;
    step(a);
  endtask

  task automatic send_col(input logic [31:0] c);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    drive_col(c);
    while (!a && n < 50) begin
      step(a);
      n++;
    end
    col_valid = 1'b0;
    if (!a) begin
      checks++; errors++;
      $display("FAIL send_timeout: column %h not accepted in 50 clocks", c);
    end
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    col_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
      step(a);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bit a;
    col_valid = 1'b0;
    reset = 1'b1;
    repeat (3) step(a);
    reset = 1'b0;
    step(a);
    checks++;
    if (col_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: col_ready=%b, required 1", col_ready);
    end
    repeat (4) step(a);
  endtask

  task automatic test_packet();
    bit         a;
    logic [7:0] seq [8];
    seq = '{8'hFB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFD, 8'h7C};
    apply_reset();
    drive_col(col4(8'hFB, 8'h01, 8'h02, 8'h03));
    step(a);
    checks++;
    if (!a || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pkt_latency0: accepted=%b out_valid=%b, required 1 0", a, out_valid);
    end
    drive_col(col4(8'h04, 8'h05, 8'hFD, 8'h7C));
    for (int k = 0; k < 8; k++) begin
      step(a);
      if (k == 0) col_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || toMux !== seq[k] || in_packet !== (k < 7) || pkt_done !== (k == 6)) begin
        errors++;
        $display("FAIL pkt_seq[%0d]: valid=%b toMux=%h inpkt=%b done=%b, required 1 %h %b %b",
                 k, out_valid, toMux, in_packet, pkt_done, seq[k], k < 7, k == 6);
      end
    end
    drain();
    checks++;
    if (pkt_len !== 8'd5) begin
      errors++;
      $display("FAIL pkt_len: pkt_len=%0d, required 5", pkt_len);
    end
  endtask

  task automatic test_back_to_back();
    bit          a;
    bit          seen_full;
    logic [31:0] cols [4];
    int          i, cyc, first, last, nvalid;
    apply_reset();
    for (int k = 0; k < 4; k++) cols[k] = $urandom;
    i = 0; cyc = 0; first = -1; last = -1; nvalid = 0; seen_full = 1'b0;
    while (nvalid < 16 && cyc < 200) begin
      if (i < 4) drive_col(cols[i]);
      else col_valid = 1'b0;
      step(a);
      if (a) i++;
      if (col_ready === 1'b0) seen_full = 1'b1;
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        nvalid++;
      end
      cyc++;
    end
    col_valid = 1'b0;
    checks++;
    if (i != 4 || !seen_full || nvalid != 16 || last - first + 1 != 16) begin
      errors++;
      $display("FAIL back_to_back: accepted=%0d full_seen=%b bytes=%0d span=%0d, required 4 1 16 16",
               i, seen_full, nvalid, last - first + 1);
    end
    drain();
  endtask

  task automatic test_framing_err();
    bit a;
    int nerr, nin;
    apply_reset();
    send_col(col4(8'h7C, 8'hFB, 8'hFF, 8'hFF));
    nerr = 0; nin = 0;
    repeat (8) begin
      step(a);
      if (framing_err === 1'b1) nerr++;
      if (in_packet === 1'b1) nin++;
    end
    checks++;
    if (nerr != 3 || nin != 0) begin
      errors++;
      $display("FAIL framing_err_count: pulses=%0d inpkt_cycles=%0d, required 3 0", nerr, nin);
    end
  endtask

  task automatic test_skp();
    bit a;
    int nvalid, nskp, xvalid, xskp;
    apply_reset();
`ifdef UNSTRIPING_SKP_DROP_EN
    xvalid = 8;  xskp = 0;
`else
    xvalid = 12; xskp = 4;
`endif
    nvalid = 0; nskp = 0;
    send_col({4{IDL}});
    if (out_valid === 1'b1) nvalid++;
    send_col({4{SKP}});
    if (out_valid === 1'b1) begin nvalid++; if (toMux === SKP) nskp++; end
    send_col({4{IDL}});
    if (out_valid === 1'b1) begin nvalid++; if (toMux === SKP) nskp++; end
    repeat (20) begin
      step(a);
      if (out_valid === 1'b1) begin
        nvalid++;
        if (toMux === SKP) nskp++;
      end
    end
    checks++;
    if (nvalid != xvalid || nskp != xskp) begin
      errors++;
      $display("FAIL skp_column: bytes=%0d skp_bytes=%0d, required %0d %0d", nvalid, nskp, xvalid, xskp);
    end
  endtask

  task automatic test_reset_mid();
    bit a;
    int nvalid;
    apply_reset();
    send_col(col4(8'hFB, 8'hFF, 8'hFF, 8'hFF));
    step(a);
    step(a);
    reset = 1'b1;
    step(a);
    reset = 1'b0;
    step(a);
    nvalid = 0;
    repeat (6) begin
      step(a);
      if (out_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0 || in_packet !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: bytes_after=%0d inpkt=%b, required 0 0", nvalid, in_packet);
    end
    send_col(col4(8'hFD, 8'h7C, 8'h7C, 8'h7C));
    step(a);
    checks++;
    if (toMux !== 8'hFD || framing_err !== 1'b1) begin
      errors++;
      $display("FAIL end_after_reset: toMux=%h ferr=%b, required fd 1", toMux, framing_err);
    end
    drain();
  endtask

  task automatic test_saturate();
    apply_reset();
    send_col(col4(STP, 8'h01, 8'h02, 8'h03));
    for (int k = 0; k < 70; k++) send_col({4{8'(k)}} | 32'h10101010);
    send_col(col4(ENDS, IDL, IDL, IDL));
    drain();
    checks++;
    if (pkt_len !== 8'd255) begin
      errors++;
      $display("FAIL pkt_len_saturate: pkt_len=%0d, required 255", pkt_len);
    end
  endtask

  task automatic test_random();
    bit          a;
    logic [31:0] c;
    apply_reset();
    c = col4(rand_sym(), rand_sym(), rand_sym(), rand_sym());
    for (int n = 0; n < 400; n++) begin
      if (col_valid || $urandom_range(0, 3) != 0) drive_col(c);
      step(a);
      if (a) begin
        c = col4(rand_sym(), rand_sym(), rand_sym(), rand_sym());
        if ($urandom_range(0, 4) == 0) c[7:0] = STP;
        col_valid = ($urandom_range(0, 2) != 0);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_packet();
    test_back_to_back();
    test_framing_err();
    test_skp();
    test_reset_mid();
    test_saturate();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d bytes never emitted, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
